cpm_rst_seq: RTL and testbench

Synchronous reset/bring-up sequencer for the CPM PCIe controller. It owns the power-on reset (POR), the CPM LPD POR, and both PERST# outputs, and releases them in a fixed order with programmable dwell times. It then waits for link-up with a timeout and retries the full sequence a bounded number of times. It sits between system reset/software start and the CIPS/CPM reset inputs, in the endpoint or root-port wrapper.

---
 rtl/cpm_rst_seq.sv | 187 ++++++++++++++++++
 tb/tb_cpm_rst_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/cpm_rst_seq.sv
// Reset/bring-up sequencer for the CPM PCIe controller: POR, CPM POR, then PERST# release, link-up wait with bounded retry.
// Optional macro CPM_RSTSEQ_LINK_SYNC_EN inserts a two-flop synchronizer on link_up_i.
module cpm_rst_seq #(
    parameter int unsigned POR_HOLD_CYC     = 500,
    parameter int unsigned PERST_DELAY_CYC  = 16,
    parameter int unsigned LINK_TIMEOUT_CYC = 100000,
    parameter int unsigned MAX_RETRY        = 3,
    parameter int unsigned CNT_W            = 20
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       start_i,
    input  logic       link_up_i,
    output logic       por_n_o,
    output logic       cpm_por_n_o,
    output logic       perst0_n_o,
    output logic       perst1_n_o,
    output logic       seq_ready_o,
    output logic       seq_err_o,
    output logic [2:0] state_o,
    output logic [1:0] retry_cnt_o
);

    localparam int unsigned RETRY_W = 2;
    localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(POR_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0]   DLY_LAST  = CNT_W'(PERST_DELAY_CYC - 1);
    localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(LINK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_HOLD      = 3'd1,
        S_REL_POR   = 3'd2,
        S_REL_PERST = 3'd3,
        S_WAIT_LINK = 3'd4,
        S_READY     = 3'd5,
        S_FAIL      = 3'd6,
        S_BAD       = 3'd7
    } state_e;

    state_e               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt, cnt_inc;
    logic [RETRY_W-1:0]   retry, retry_nxt;
    logic                 link_s;
    logic                 por_nxt, perst_nxt, rdy_nxt, err_nxt;

`ifdef CPM_RSTSEQ_LINK_SYNC_EN
    logic [1:0] link_sync;

    // Two-flop synchronizer for the asynchronous link-up status
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            link_sync <= 2'b00;
        end else begin
            link_sync <= {link_sync[0], link_up_i};
        end
    end

    assign link_s = link_sync[1];
`else
    assign link_s = link_up_i;
`endif

    // State, dwell counter, retry count and registered output decode
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            retry       <= '0;
            por_n_o     <= 1'b0;
            cpm_por_n_o <= 1'b0;
            perst0_n_o  <= 1'b0;
            perst1_n_o  <= 1'b0;
            seq_ready_o <= 1'b0;
            seq_err_o   <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            retry       <= retry_nxt;
            por_n_o     <= por_nxt;
            cpm_por_n_o <= por_nxt;
            perst0_n_o  <= perst_nxt;
            perst1_n_o  <= perst_nxt;
            seq_ready_o <= rdy_nxt;
            seq_err_o   <= err_nxt;
        end
    end

    // Saturating dwell increment
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_inc;
        retry_nxt = retry;
        por_nxt   = 1'b0;
        perst_nxt = 1'b0;
        rdy_nxt   = 1'b0;
        err_nxt   = 1'b0;

        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (start_i) begin
                    state_nxt = S_HOLD;
                    retry_nxt = '0;
                end
            end
            S_HOLD: begin
                if (cnt == HOLD_LAST) begin
                    state_nxt = S_REL_POR;
                    cnt_nxt   = '0;
                end
            end
            S_REL_POR: begin
                if (cnt == DLY_LAST) begin
                    state_nxt = S_REL_PERST;
                    cnt_nxt   = '0;
                end
            end
            S_REL_PERST: begin
                state_nxt = S_WAIT_LINK;
                cnt_nxt   = '0;
            end
            S_WAIT_LINK: begin
                // Link-up beats a coincident timeout
                if (link_s) begin
                    state_nxt = S_READY;
                    cnt_nxt   = '0;
                end else if (cnt == TO_LAST) begin
                    cnt_nxt = '0;
                    if (retry < RETRY_MAX) begin
                        retry_nxt = retry + RETRY_W'(1);
                        state_nxt = S_HOLD;
                    end else begin
                        state_nxt = S_FAIL;
                    end
                end
            end
            S_READY: begin
                cnt_nxt = '0;
                if (!link_s) begin
                    state_nxt = S_WAIT_LINK;
                end
            end
            S_FAIL: begin
                cnt_nxt = '0;
                if (start_i) begin
                    state_nxt = S_HOLD;
                    retry_nxt = '0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
                retry_nxt = '0;
            end
        endcase

        // Outputs follow the state being entered so they align with state_o
        case (state_nxt)
            S_REL_POR: begin
                por_nxt = 1'b1;
            end
            S_REL_PERST, S_WAIT_LINK: begin
                por_nxt   = 1'b1;
                perst_nxt = 1'b1;
            end
            S_READY: begin
                por_nxt   = 1'b1;
                perst_nxt = 1'b1;
                rdy_nxt   = 1'b1;
            end
            S_FAIL: begin
                err_nxt = 1'b1;
            end
            default: begin
                por_nxt = 1'b0;
            end
        endcase
    end

    assign state_o     = state;
    assign retry_cnt_o = retry;

endmodule

// File: tb/tb_cpm_rst_seq.sv
// Bench for cpm_rst_seq: directed scenarios plus randomized link-up timing against a timeline model.
module tb_cpm_rst_seq;

    localparam int H     = 8;
    localparam int D     = 4;
    localparam int T     = 20;
    localparam int MR    = 2;
    localparam int P     = H + D + 1 + T;
    localparam int NEVER = 1000000;
`ifdef CPM_RSTSEQ_LINK_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic       start_i;
    logic       link_up_i;
    logic       por_n_o;
    logic       cpm_por_n_o;
    logic       perst0_n_o;
    logic       perst1_n_o;
    logic       seq_ready_o;
    logic       seq_err_o;
    logic [2:0] state_o;
    logic [1:0] retry_cnt_o;

    int errors = 0;
    int checks = 0;

    always #5 sys_clk = ~sys_clk;

    cpm_rst_seq #(
        .POR_HOLD_CYC    (H),
        .PERST_DELAY_CYC (D),
        .LINK_TIMEOUT_CYC(T),
        .MAX_RETRY       (MR),
        .CNT_W           (20)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .start_i    (start_i),
        .link_up_i  (link_up_i),
        .por_n_o    (por_n_o),
        .cpm_por_n_o(cpm_por_n_o),
        .perst0_n_o (perst0_n_o),
        .perst1_n_o (perst1_n_o),
        .seq_ready_o(seq_ready_o),
        .seq_err_o  (seq_err_o),
        .state_o    (state_o),
        .retry_cnt_o(retry_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic check_all(input string tag, input int st, input int rt);
        chk({tag, ".state"}, 32'(state_o), 32'(st));
        chk({tag, ".retry"}, 32'(retry_cnt_o), 32'(rt));
        chk({tag, ".por_n"}, 32'(por_n_o), 32'(st >= 2 && st <= 5));
        chk({tag, ".cpm_por_n"}, 32'(cpm_por_n_o), 32'(st >= 2 && st <= 5));
        chk({tag, ".perst0_n"}, 32'(perst0_n_o), 32'(st >= 3 && st <= 5));
        chk({tag, ".perst1_n"}, 32'(perst1_n_o), 32'(st >= 3 && st <= 5));
        chk({tag, ".ready"}, 32'(seq_ready_o), 32'(st == 5));
        chk({tag, ".err"}, 32'(seq_err_o), 32'(st == 6));
    endtask

    // Timeline model: o = edges since the start edge, L = first edge link_up_i is sampled high
    function automatic void model(input int o, input int L, output int st, output int rt);
        int ks, first, last, e, rdy_e, rdy_r, a, r;
        rdy_e = -1;
        rdy_r = 0;
        ks    = L + SYNC;
        for (int k = 0; k <= MR; k++) begin
            first = k * P + H + D + 2;
            last  = (k + 1) * P;
            e     = (ks > first) ? ks : first;
            if (rdy_e < 0 && e <= last) begin
                rdy_e = e;
                rdy_r = k;
            end
        end
        if (rdy_e >= 0 && o >= rdy_e) begin
            st = 5;
            rt = rdy_r;
        end else if (rdy_e < 0 && o >= (MR + 1) * P) begin
            st = 6;
            rt = MR;
        end else begin
            a  = o / P;
            r  = o % P;
            rt = a;
            if (r < H)          st = 1;
            else if (r < H + D) st = 2;
            else if (r == H + D) st = 3;
            else                st = 4;
        end
    endfunction

    task automatic apply_reset();
        sys_rst_n = 1'b0;
        start_i   = 1'b0;
        link_up_i = 1'b0;
        @(posedge sys_clk);
        #1;
        check_all("reset", 0, 0);
        sys_rst_n = 1'b1;
    endtask

    task automatic run_trial(input string tag, input int L, input bit extra, input bit do_reset,
                             output int fin_st, output int fin_rt);
        int st, rt;
        if (do_reset) apply_reset();
        start_i   = 1'b1;
        link_up_i = (L <= 0);
        @(posedge sys_clk);
        #1;
        start_i = 1'b0;
        model(0, L, st, rt);
        check_all({tag, ".start"}, st, rt);
        for (int o = 1; o <= 3 * P + 4; o++) begin
            link_up_i = (o >= L);
            start_i   = extra && (o == 3);
            @(posedge sys_clk);
            #1;
            model(o, L, st, rt);
            check_all(tag, st, rt);
        end
        start_i = 1'b0;
        fin_st  = st;
        fin_rt  = rt;
    endtask

    initial begin
        int  st, rt, L, exp_st;
        bit  extra;
        sys_rst_n = 1'b0;
        start_i   = 1'b0;
        link_up_i = 1'b0;

        // Nominal bring-up: link arrives 20 cycles after start
        run_trial("nominal", 20, 1'b0, 1'b1, st, rt);
        chk("nominal.final_state", 32'(state_o), 32'(5));

        // Link never comes: three timeouts, then FAIL
        run_trial("no_link", NEVER, 1'b0, 1'b1, st, rt);
        chk("no_link.final_state", 32'(state_o), 32'(6));

        // Restart from FAIL clears retries and reaches READY
        run_trial("fail_restart", 5, 1'b0, 1'b0, st, rt);

        // READY, then link drops for three samples and returns
        run_trial("second_try", P + 5, 1'b0, 1'b1, st, rt);
        for (int j = 0; j <= SYNC + 5; j++) begin
            link_up_i = !(j < 3);
            @(posedge sys_clk);
            #1;
            exp_st = (j >= SYNC && j < SYNC + 3) ? 4 : 5;
            check_all("link_drop", exp_st, 1);
        end

        // Reset pulse in the middle of REL_POR
        apply_reset();
        start_i = 1'b1;
        @(posedge sys_clk);
        #1;
        start_i = 1'b0;
        repeat (H + 1) @(posedge sys_clk);
        #1;
        check_all("in_rel_por", 2, 0);
        sys_rst_n = 1'b0;
        @(posedge sys_clk);
        #1;
        check_all("mid_reset", 0, 0);
        sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
        check_all("post_reset_idle", 0, 0);

        // Link seen exactly on the last timeout edge of each attempt
        run_trial("edge_first", P - SYNC, 1'b0, 1'b1, st, rt);
        run_trial("edge_final", 3 * P - SYNC, 1'b1, 1'b1, st, rt);
        chk("edge_final.retry", 32'(retry_cnt_o), 32'(MR));
        run_trial("early_link", 2, 1'b1, 1'b1, st, rt);

        // Randomized link-up timing and stray start pulses
        for (int n = 0; n < 16; n++) begin
            L     = ($urandom_range(0, 3) == 0) ? NEVER : int'($urandom_range(0, 3 * P + 2));
            extra = 1'($urandom_range(0, 1));
            run_trial("random", L, extra, 1'b1, st, rt);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
